// File: rtl/crypt_round_sequencer.sv
// Round sequencer around the combinational Stage4 word permutation: captures one
// block plus round key, runs NUM_ROUNDS Stage4 passes, then offers the result downstream.
//
// state  | meaning
// S_IDLE | waiting for a block; in_ready high
// S_RUN  | one Stage4 round per cycle, result written back to r_state_reg
// S_DONE | final block presented on out_block until out_ready
module crypt_round_sequencer #(
  parameter int NUM_ROUNDS = 8,
  parameter int KEY_W      = 2*NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  input  logic [KEY_W-1:0] in_key,
  output logic             stage_en,
  output logic             stage_k2,
  output logic             stage_k3,
  output logic [127:0]     stage_in,
  input  logic [127:0]     stage_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic             busy,
  output logic [3:0]       round_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [127:0]       r_state_reg;
  logic [KEY_W-1:0]   r_key_sr;
  logic [3:0]         r_round_cnt;
  logic               w_last_round;

  assign w_last_round = (r_round_cnt == LAST_ROUND);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_state_reg <= '0;
      r_key_sr    <= '0;
      r_round_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state_reg <= in_block;
            r_key_sr    <= in_key;
            r_round_cnt <= '0;
          end
        end
        S_RUN: begin
          // Key pairs are consumed LSB-first, so the next round's pair is always at [1:0].
          r_state_reg <= stage_out;
          r_key_sr    <= r_key_sr >> 2;
          r_round_cnt <= w_last_round ? 4'd0 : r_round_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    stage_en    = 1'b0;
    stage_k2    = 1'b0;
    stage_k3    = 1'b0;
    out_valid   = 1'b0;
    out_block   = '0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        stage_en = 1'b1;
        stage_k2 = r_key_sr[0];
        stage_k3 = r_key_sr[1];
        busy     = 1'b1;
        if (w_last_round) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_block = r_state_reg;
        busy      = 1'b1;
        // Return to IDLE only; a new block is taken the following cycle.
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign stage_in  = r_state_reg;
  assign round_cnt = r_round_cnt;

endmodule

// File: tb/tb_crypt_round_sequencer.sv
// Directed bench for crypt_round_sequencer: a 1-round and an 8-round instance,
// each closed through a behavioural Stage4 word-permutation model.
module tb_crypt_round_sequencer;

  localparam logic [31:0]  WA  = 32'h00010203;
  localparam logic [31:0]  WB  = 32'h04050607;
  localparam logic [31:0]  WC  = 32'h08090A0B;
  localparam logic [31:0]  WD  = 32'h0C0D0E0F;
  localparam logic [127:0] ABCD = {WA, WB, WC, WD};

  logic clk, rst;

  logic         in_valid1, in_ready1, stage_en1, stage_k2_1, stage_k3_1;
  logic         out_valid1, out_ready1, busy1;
  logic [127:0] in_block1, stage_in1, stage_out1, out_block1;
  logic [1:0]   in_key1;
  logic [3:0]   round_cnt1;

  logic         in_valid8, in_ready8, stage_en8, stage_k2_8, stage_k3_8;
  logic         out_valid8, out_ready8, busy8;
  logic [127:0] in_block8, stage_in8, stage_out8, out_block8;
  logic [15:0]  in_key8;
  logic [3:0]   round_cnt8;

  int total = 0;
  int bad   = 0;

  // Stage4: disabled = pass-through; {k3,k2} picks one of four word swaps.
  function automatic logic [127:0] stage4(input logic en, input logic k2, input logic k3,
                                          input logic [127:0] x);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = x;
    if (!en) return x;
    case ({k3, k2})
      2'b00:   return {b, a, d, c};
      2'b01:   return {d, b, c, a};
      2'b10:   return {a, c, b, d};
      default: return {a, d, c, b};
    endcase
  endfunction

  always_comb stage_out1 = stage4(stage_en1, stage_k2_1, stage_k3_1, stage_in1);
  always_comb stage_out8 = stage4(stage_en8, stage_k2_8, stage_k3_8, stage_in8);

  crypt_round_sequencer #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_block(in_block1), .in_key(in_key1), .stage_en(stage_en1),
    .stage_k2(stage_k2_1), .stage_k3(stage_k3_1), .stage_in(stage_in1),
    .stage_out(stage_out1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_block(out_block1), .busy(busy1), .round_cnt(round_cnt1)
  );

  crypt_round_sequencer #(.NUM_ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_block(in_block8), .in_key(in_key8), .stage_en(stage_en8),
    .stage_k2(stage_k2_8), .stage_k3(stage_k3_8), .stage_in(stage_in8),
    .stage_out(stage_out8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_block(out_block8), .busy(busy8), .round_cnt(round_cnt8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Send one block to the 1-round instance; lat = negedges after the accept edge until out_valid.
  task automatic run1(input logic [1:0] key, input logic [127:0] blk,
                      output logic [127:0] res, output int lat);
    @(negedge clk);
    in_valid1 = 1'b1; in_block1 = blk; in_key1 = key;
    lat = 0;
    while (!in_ready1 && lat < 20) begin @(negedge clk); lat++; end
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 50) begin @(negedge clk); lat++; end
    res = out_block1;
    if (!out_valid1) lat = -1;
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
  endtask

  task automatic run8(input logic [15:0] key, input logic [127:0] blk,
                      output logic [127:0] res, output int lat);
    @(negedge clk);
    in_valid8 = 1'b1; in_block8 = blk; in_key8 = key;
    lat = 0;
    while (!in_ready8 && lat < 20) begin @(negedge clk); lat++; end
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin @(negedge clk); lat++; end
    res = out_block8;
    if (!out_valid8) lat = -1;
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready1: got %b want 1", in_ready1); end
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready8: got %b want 1", in_ready8); end
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
    total++; if (stage_en8 !== 1'b0) begin bad++; $display("FAIL reset_stage_en: got %b want 0", stage_en8); end
    total++; if (round_cnt8 !== 4'd0) begin bad++; $display("FAIL reset_round_cnt: got %0d want 0", round_cnt8); end
    total++; if (stage_in8 !== 128'h0) begin bad++; $display("FAIL reset_stage_in: got %h want 0", stage_in8); end
    total++; if (out_block8 !== 128'h0) begin bad++; $display("FAIL reset_out_block: got %h want 0", out_block8); end
    rst = 1'b0;
  endtask

  task automatic test_single_round();
    logic [127:0] res;
    int lat;
    run1(2'b01, ABCD, res, lat);
    total++; if (res !== {WD, WB, WC, WA}) begin bad++; $display("FAIL single_key01: got %h want %h", res, {WD, WB, WC, WA}); end
    total++; if (lat !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1", lat); end
  endtask

  task automatic test_key_patterns();
    logic [1:0]   keys [3];
    logic [127:0] exp_b [3];
    logic [127:0] res;
    int lat;
    keys[0] = 2'b00; exp_b[0] = {WB, WA, WD, WC};
    keys[1] = 2'b10; exp_b[1] = {WA, WC, WB, WD};
    keys[2] = 2'b11; exp_b[2] = {WA, WD, WC, WB};
    for (int i = 0; i < 3; i++) begin
      run1(keys[i], ABCD, res, lat);
      total++; if (res !== exp_b[i]) begin bad++; $display("FAIL key_pattern_%0d: got %h want %h", i, res, exp_b[i]); end
      total++; if (lat !== 1) begin bad++; $display("FAIL key_pattern_lat_%0d: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_eight_rounds();
    logic [127:0] st_exp [4];
    logic [127:0] res;
    int lat, n;
    run8(16'h0000, ABCD, res, lat);
    total++; if (res !== ABCD) begin bad++; $display("FAIL eight_key0: got %h want %h", res, ABCD); end
    total++; if (lat !== 8) begin bad++; $display("FAIL eight_latency: got %0d want 8", lat); end
    // Key 9999: rounds alternate {k3,k2}=01 and 10, cycling the state through four values.
    st_exp[0] = ABCD;
    st_exp[1] = {WD, WB, WC, WA};
    st_exp[2] = {WD, WC, WB, WA};
    st_exp[3] = {WA, WC, WB, WD};
    @(negedge clk);
    in_valid8 = 1'b1; in_block8 = ABCD; in_key8 = 16'h9999;
    n = 0;
    while (!in_ready8 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid8 = 1'b0;
    for (int r = 0; r < 8; r++) begin
      total++; if (round_cnt8 !== 4'(r)) begin bad++; $display("FAIL run_round_cnt_%0d: got %0d want %0d", r, round_cnt8, r); end
      total++; if (stage_in8 !== st_exp[r % 4]) begin bad++; $display("FAIL run_stage_in_%0d: got %h want %h", r, stage_in8, st_exp[r % 4]); end
      total++; if ({stage_en8, stage_k3_8, stage_k2_8} !== {1'b1, r[0], ~r[0]})
        begin bad++; $display("FAIL run_stage_ctl_%0d: got %b want %b", r, {stage_en8, stage_k3_8, stage_k2_8}, {1'b1, r[0], ~r[0]}); end
      total++; if ({out_valid8, in_ready8, busy8} !== 3'b001) begin bad++; $display("FAIL run_hs_%0d: got %b want 001", r, {out_valid8, in_ready8, busy8}); end
      @(negedge clk);
    end
    total++; if (out_valid8 !== 1'b1) begin bad++; $display("FAIL run_done_valid: got %b want 1", out_valid8); end
    total++; if (out_block8 !== ABCD) begin bad++; $display("FAIL run_done_block: got %h want %h", out_block8, ABCD); end
    total++; if (round_cnt8 !== 4'd0) begin bad++; $display("FAIL run_done_cnt: got %0d want 0", round_cnt8); end
    total++; if (stage_en8 !== 1'b0) begin bad++; $display("FAIL run_done_en: got %b want 0", stage_en8); end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk);
    in_valid8 = 1'b1; in_block8 = ABCD; in_key8 = 16'h0000;
    @(negedge clk);
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
    total++; if (out_valid8 !== 1'b1) begin bad++; $display("FAIL hold_reach_done: got %b want 1", out_valid8); end
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'b1; in_block8 = {WD, WC, WB, WA}; in_key8 = 16'hFFFF;
      @(negedge clk);
      total++; if (out_block8 !== ABCD) begin bad++; $display("FAIL hold_block_%0d: got %h want %h", i, out_block8, ABCD); end
      total++; if ({out_valid8, in_ready8} !== 2'b10) begin bad++; $display("FAIL hold_hs_%0d: got %b want 10", i, {out_valid8, in_ready8}); end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    total++; if ({out_valid8, in_ready8, busy8} !== 3'b010) begin bad++; $display("FAIL hold_after_hs: got %b want 010", {out_valid8, in_ready8, busy8}); end
    total++; if (out_block8 !== 128'h0) begin bad++; $display("FAIL hold_block_zero: got %h want 0", out_block8); end
  endtask

  task automatic test_reset_midrun();
    logic [127:0] res;
    int lat, n;
    logic seen_valid;
    @(negedge clk);
    in_valid8 = 1'b1; in_block8 = {WD, WC, WB, WA}; in_key8 = 16'h1234;
    @(negedge clk);
    in_valid8 = 1'b0;
    n = 0;
    while (round_cnt8 !== 4'd3 && n < 20) begin @(negedge clk); n++; end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy8); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready8); end
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid8); end
    total++; if (round_cnt8 !== 4'd0) begin bad++; $display("FAIL rstmid_round_cnt: got %0d want 0", round_cnt8); end
    total++; if (stage_in8 !== 128'h0) begin bad++; $display("FAIL rstmid_stage_in: got %h want 0", stage_in8); end
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid8) seen_valid = 1'b1;
    end
    total++; if (seen_valid !== 1'b0) begin bad++; $display("FAIL rstmid_discard: got out_valid=%b want 0", seen_valid); end
    run8(16'h0000, ABCD, res, lat);
    total++; if (res !== ABCD) begin bad++; $display("FAIL rstmid_next_block: got %h want %h", res, ABCD); end
    total++; if (lat !== 8) begin bad++; $display("FAIL rstmid_next_lat: got %0d want 8", lat); end
  endtask

  task automatic test_back_to_back();
    int acc_c [2];
    int out_c [2];
    logic [127:0] out_b [2];
    int nacc, nout;
    nacc = 0; nout = 0;
    acc_c[0] = -1; acc_c[1] = -1; out_c[0] = -1; out_c[1] = -1;
    out_b[0] = '0; out_b[1] = '0;
    out_ready1 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (nacc == 0) begin in_valid1 = 1'b1; in_block1 = ABCD; in_key1 = 2'b01; end
      else if (nacc == 1) begin in_valid1 = 1'b1; in_block1 = ABCD; in_key1 = 2'b00; end
      else in_valid1 = 1'b0;
      if (in_valid1 && in_ready1 && nacc < 2) begin acc_c[nacc] = c; nacc++; end
      if (out_valid1 && nout < 2) begin out_c[nout] = c; out_b[nout] = out_block1; nout++; end
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    total++; if (out_b[0] !== {WD, WB, WC, WA}) begin bad++; $display("FAIL b2b_first: got %h want %h", out_b[0], {WD, WB, WC, WA}); end
    total++; if (out_b[1] !== {WB, WA, WD, WC}) begin bad++; $display("FAIL b2b_second: got %h want %h", out_b[1], {WB, WA, WD, WC}); end
    total++; if (out_c[0] - acc_c[0] !== 2) begin bad++; $display("FAIL b2b_first_lat: got %0d want 2", out_c[0] - acc_c[0]); end
    total++; if (acc_c[1] - out_c[0] !== 1) begin bad++; $display("FAIL b2b_second_accept: got %0d want 1", acc_c[1] - out_c[0]); end
    total++; if (out_c[1] - out_c[0] !== 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", out_c[1] - out_c[0]); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid1 = 1'b0; in_block1 = '0; in_key1 = '0; out_ready1 = 1'b0;
    in_valid8 = 1'b0; in_block8 = '0; in_key8 = '0; out_ready8 = 1'b0;
    test_reset();
    test_single_round();
    test_key_patterns();
    test_eight_rounds();
    test_hold();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
